spi_xfer_sequencer: RTL

- Byte-stream front end that sits directly upstream of the SPI master and feeds it.
- Host writes bytes into a TX FIFO. The sequencer launches one SPI master transfer per byte by driving the master's start and data_in.
- It detects transfer completion from the master's chip-select returning high, then pushes the master's received byte into an RX FIFO for the host to read.

---
 rtl/spi_xfer_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for an SPI master: TX FIFO feeds one master transfer per byte,
// completion is detected from chip-select returning high, and the received byte lands in an RX FIFO.
module spi_xfer_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     m_start,
    output logic [7:0]               m_data_in,
    input  logic [7:0]               m_data_out,
    input  logic                     m_cs,
    output logic                     busy,
    output logic                     wr_drop,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE
    } state_t;

    state_t state;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [AW:0]   tx_cnt;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [AW:0]   rx_cnt;

    logic launch;
    logic tx_push;
    logic tx_pop;
    logic rx_push;
    logic rx_pop;

    // Launch only when RX has room: RX cannot gain entries while a transfer is in flight.
    assign launch  = (state == IDLE) && (tx_cnt != '0) && (rx_cnt != FULL_CNT);
    assign tx_push = wr_en && !tx_full;
    assign tx_pop  = launch;
    assign rx_push = (state == CAPTURE);
    assign rx_pop  = rd_en && !rx_empty;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_count = tx_cnt;
    assign rx_empty = (rx_cnt == '0);
    assign rx_count = rx_cnt;
    assign rd_data  = rx_empty ? 8'h00 : rx_mem[rx_rptr];

    // NOTE: storage arrays carry no reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= wr_data;
        if (rx_push) rx_mem[rx_wptr] <= m_data_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // A set request outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_drop <= 1'b0;
        end else if (wr_en && tx_full) begin
            wr_drop <= 1'b1;
        end else if (clr_err) begin
            wr_drop <= 1'b0;
        end
    end

    // NOTE: non-blocking assignments here so every output updates on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            m_start   <= 1'b0;
            m_data_in <= 8'h00;
            busy      <= 1'b0;
        end else begin
            m_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        m_data_in <= tx_mem[tx_rptr];
                        m_start   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!m_cs) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (m_cs) state <= CAPTURE;
                end
                CAPTURE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
